// File: rtl/alu_cmd_ctrl_if.sv
// Bus bundle between the command parser, the ALU datapath and the UART transmit side.
// The controller takes the slave view; the surrounding environment takes the master view.
interface alu_cmd_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_dtype;
    logic [4:0]  cmd_op;
    logic [15:0] cmd_src1;
    logic [15:0] cmd_src2;

    logic        alu_start;
    logic [3:0]  alu_dtype;
    logic [4:0]  alu_op;
    logic [15:0] alu_src1;
    logic [15:0] alu_src2;
    logic        alu_done;
    logic [31:0] alu_result;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_err;

    modport slave (
        input  cmd_valid, cmd_dtype, cmd_op, cmd_src1, cmd_src2,
        output cmd_ready,
        output alu_start, alu_dtype, alu_op, alu_src1, alu_src2,
        input  alu_done, alu_result,
        output rsp_valid, rsp_result, rsp_err,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_dtype, cmd_op, cmd_src1, cmd_src2,
        input  cmd_ready,
        input  alu_start, alu_dtype, alu_op, alu_src1, alu_src2,
        output alu_done, alu_result,
        input  rsp_valid, rsp_result, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer for the UART calculator: buffers parsed commands, screens illegal ones
// and divide-by-zero, issues them one at a time to the ALU and returns one response each.
module alu_cmd_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    parameter int DRAIN_CYC  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    alu_cmd_ctrl_if.slave               bus,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int TMR_MAX = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [3:0] DT_UNSIGNED = 4'h1;
    localparam logic [3:0] DT_SIGNED   = 4'h2;
    localparam logic [4:0] OP_ADD      = 5'h01;
    localparam logic [4:0] OP_SUB      = 5'h02;
    localparam logic [4:0] OP_MUL      = 5'h04;
    localparam logic [4:0] OP_DIV      = 5'h08;
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_DIVZERO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN
    } state_e;

    typedef struct packed {
        logic [3:0]  dtype;
        logic [4:0]  op;
        logic [15:0] src1;
        logic [15:0] src2;
    } cmd_t;

    state_e            state_q, state_d;
    cmd_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    cmd_t              wk_q;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic [1:0]        rsp_err_q, rsp_err_d;

    logic full, empty, push, pop;
    logic legal, div_zero, tmr_expired, drain_done, issuing;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = bus.cmd_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    assign legal = ((wk_q.dtype == DT_UNSIGNED) || (wk_q.dtype == DT_SIGNED)) &&
                   (wk_q.op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV});
    assign div_zero    = (wk_q.op == OP_DIV) && (wk_q.src2 == '0);
    assign tmr_expired = (timer_q == TMR_W'(TIMEOUT - 1));
    assign drain_done  = (timer_q == TMR_W'(DRAIN_CYC - 1));

    // NOTE: every signal written in always_comb is given a default first so no latch is inferred.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d      = S_RESP;
                    rsp_err_d    = ERR_ILLEGAL;
                    rsp_result_d = '0;
                end else if (div_zero) begin
                    state_d      = S_RESP;
                    rsp_err_d    = ERR_DIVZERO;
                    rsp_result_d = '0;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the last allowed cycle still counts as success.
                if (bus.alu_done) begin
                    state_d      = S_RESP;
                    rsp_err_d    = ERR_OK;
                    rsp_result_d = bus.alu_result;
                end else if (tmr_expired) begin
                    state_d      = S_RESP;
                    rsp_err_d    = ERR_TIMEOUT;
                    rsp_result_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    if (rsp_err_q == ERR_TIMEOUT) begin
                        state_d = S_DRAIN;
                        timer_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the FIFO storage has no reset; the pointers and level alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{dtype: bus.cmd_dtype, op: bus.cmd_op,
                                    src1: bus.cmd_src1, src2: bus.cmd_src2};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            wk_q         <= '0;
            timer_q      <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                wk_q     <= fifo_mem[rd_ptr_q];
            end
            level_q      <= level_d;
            timer_q      <= timer_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign issuing = (state_q == S_ISSUE) || (state_q == S_WAIT);

    always_comb begin
        bus.cmd_ready  = !full;
        bus.alu_start  = (state_q == S_ISSUE);
        bus.alu_dtype  = issuing ? wk_q.dtype : 4'h0;
        bus.alu_op     = issuing ? wk_q.op : 5'h00;
        bus.alu_src1   = wk_q.src1;
        bus.alu_src2   = wk_q.src2;
        bus.rsp_valid  = (state_q == S_RESP);
        bus.rsp_result = rsp_result_q;
        bus.rsp_err    = rsp_err_q;
        busy           = (state_q != S_IDLE);
        fifo_level     = level_q;
    end
endmodule
